// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divide unit.
interface div_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        input  result_o, ready_o, busy_o, reg_waddr_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        output result_o, ready_o, busy_o, reg_waddr_o
    );
endinterface

// File: rtl/div.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring division, one quotient bit per cycle.
//  state  | meaning
//  S_IDLE | waiting for a request with op_i[2]=1
//  S_CALC | 32 restoring steps on operand magnitudes
//  S_END  | one-cycle ready_o pulse with result and write-back address
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [32:0] rem;
    logic [31:0] dvd, dvs, quo;
    logic [31:0] result_q;
    logic [4:0]  waddr_q;
    logic        is_rem, neg_q, neg_r;

    logic        accept, div_zero, is_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_sh, rem_nxt;
    logic        q_bit;
    logic [31:0] q_fin, r_fin, res_fin;

    assign accept    = (state == S_IDLE) && bus.start_i && bus.op_i[2];
    assign div_zero  = (bus.divisor_i == 32'd0);
    assign is_signed = ~bus.op_i[0];
    assign sign_a    = is_signed & bus.dividend_i[31];
    assign sign_b    = is_signed & bus.divisor_i[31];
    assign mag_a     = sign_a ? (~bus.dividend_i + 32'd1) : bus.dividend_i;
    assign mag_b     = sign_b ? (~bus.divisor_i + 32'd1) : bus.divisor_i;

    assign rem_sh  = {rem[31:0], dvd[31]};
    assign q_bit   = (rem_sh >= {1'b0, dvs});
    assign rem_nxt = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
    assign q_fin   = {quo[30:0], q_bit};
    assign r_fin   = rem_nxt[31:0];
    // Most-negative / -1 lands on 0x80000000 naturally: no negation, magnitude fits.
    assign res_fin = is_rem ? (neg_r ? (~r_fin + 32'd1) : r_fin)
                            : (neg_q ? (~q_fin + 32'd1) : q_fin);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = div_zero ? S_END : S_CALC;
            S_CALC: if (count == 5'd31) state_nxt = S_END;
            S_END:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o      = (state != S_IDLE);
        bus.ready_o     = (state == S_END);
        bus.result_o    = result_q;
        bus.reg_waddr_o = waddr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            quo      <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (accept) begin
            waddr_q <= bus.reg_waddr_i;
            is_rem  <= bus.op_i[1];
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvd     <= mag_a;
            dvs     <= mag_b;
            // Divide by zero skips CALC; remainder ops return the raw dividend.
            if (div_zero)
                result_q <= bus.op_i[1] ? bus.dividend_i : 32'hFFFF_FFFF;
        end else if (state == S_CALC) begin
            rem   <= rem_nxt;
            dvd   <= {dvd[30:0], 1'b0};
            quo   <= q_fin;
            count <= count + 5'd1;
            if (count == 5'd31)
                result_q <= res_fin;
        end
    end
endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div unit.
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    div_if bus();
    div dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] wa,
                          output int lat, output int busy_n, output int after_ok);
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a;
        bus.divisor_i = b;  bus.reg_waddr_i = rd;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 0; busy_n = 0;
        while (!bus.ready_o && lat < 50) begin
            if (bus.busy_o) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy_o) busy_n++;
        res = bus.result_o;
        wa  = bus.reg_waddr_o;
        @(posedge clk); #1;
        after_ok = (!bus.ready_o && !bus.busy_o && bus.result_o === res) ? 1 : 0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({bus.result_o, bus.ready_o, bus.busy_o, bus.reg_waddr_o} !== 39'd0) begin
            $display("FAIL reset_outputs: got %h exp 0",
                     {bus.result_o, bus.ready_o, bus.busy_o, bus.reg_waddr_o});
            fails++;
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_divu_basic();
        logic [31:0] res; logic [4:0] wa; int lat, bn, ok;
        run_op(3'b101, 32'd100, 32'd7, 5'd5, res, wa, lat, bn, ok);
        tests++; if (lat !== 32) begin $display("FAIL divu_latency: got %0d exp 32", lat); fails++; end
        tests++; if (res !== 32'd14) begin $display("FAIL divu_result: got %0d exp 14", res); fails++; end
        tests++; if (wa !== 5'd5) begin $display("FAIL divu_waddr: got %0d exp 5", wa); fails++; end
        tests++; if (bn !== 33) begin $display("FAIL divu_busy_cycles: got %0d exp 33", bn); fails++; end
        tests++; if (ok !== 1) begin $display("FAIL divu_pulse_end_hold: got %0d exp 1", ok); fails++; end
    endtask

    task automatic test_signed();
        logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b110, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd16,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd15,
                                 32'h8000_0000, 32'd0};
        logic [31:0] res; logic [4:0] wa; int lat, bn, ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 10), res, wa, lat, bn, ok);
            tests++;
            if (res !== exp[i] || wa !== 5'(i + 10) || lat !== 32) begin
                $display("FAIL signed_vec%0d: got res=%h wa=%0d lat=%0d exp res=%h wa=%0d lat=32",
                         i, res, wa, lat, exp[i], i + 10);
                fails++;
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res; logic [4:0] wa; int lat, bn, ok;
        run_op(3'b101, 32'd42, 32'd0, 5'd3, res, wa, lat, bn, ok);
        tests++; if (lat !== 0) begin $display("FAIL dz_latency: got %0d exp 0", lat); fails++; end
        tests++; if (res !== 32'hFFFF_FFFF) begin $display("FAIL dz_divu: got %h exp ffffffff", res); fails++; end
        tests++; if (bn !== 1 || ok !== 1) begin $display("FAIL dz_busy: got bn=%0d ok=%0d exp 1 1", bn, ok); fails++; end
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd4, res, wa, lat, bn, ok);
        tests++; if (res !== 32'hFFFF_FFFB || wa !== 5'd4) begin
            $display("FAIL dz_rem: got %h wa=%0d exp fffffffb wa=4", res, wa); fails++; end
    endtask

    task automatic test_non_div_op();
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.dividend_i = 32'd8; bus.divisor_i = 32'd2;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        tests++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            $display("FAIL non_div_ignored: got busy=%b ready=%b exp 0 0", bus.busy_o, bus.ready_o);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0; logic [31:0] res = '0; logic [4:0] wa = '0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b101; bus.dividend_i = 32'd100;
        bus.divisor_i = 32'd7; bus.reg_waddr_i = 5'd5;
        @(posedge clk); #1;
        bus.op_i = 3'b100; bus.dividend_i = 32'd55; bus.divisor_i = 32'd5; bus.reg_waddr_i = 5'd9;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 30) bus.start_i = 1'b0;
            if (bus.ready_o) begin pulses++; res = bus.result_o; wa = bus.reg_waddr_o; end
        end
        tests++; if (pulses !== 1) begin $display("FAIL b2b_pulses: got %0d exp 1", pulses); fails++; end
        tests++; if (res !== 32'd14 || wa !== 5'd5) begin
            $display("FAIL b2b_result: got %0d wa=%0d exp 14 wa=5", res, wa); fails++; end
    endtask

    task automatic test_reset_mid();
        int pulses = 0; logic [31:0] res; logic [4:0] wa; int lat, bn, ok;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b101; bus.dividend_i = 32'd1000;
        bus.divisor_i = 32'd3; bus.reg_waddr_i = 5'd7;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        tests++;
        if ({bus.result_o, bus.ready_o, bus.busy_o, bus.reg_waddr_o} !== 39'd0) begin
            $display("FAIL mid_reset_outputs: got %h exp 0",
                     {bus.result_o, bus.ready_o, bus.busy_o, bus.reg_waddr_o});
            fails++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) pulses++;
        end
        tests++; if (pulses !== 0) begin $display("FAIL mid_reset_no_pulse: got %0d exp 0", pulses); fails++; end
        run_op(3'b101, 32'd9, 32'd3, 5'd2, res, wa, lat, bn, ok);
        tests++; if (res !== 32'd3 || lat !== 32) begin
            $display("FAIL post_reset_divu: got %0d lat=%0d exp 3 lat=32", res, lat); fails++; end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.op_i = '0; bus.dividend_i = '0;
        bus.divisor_i = '0; bus.reg_waddr_i = '0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_non_div_op();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
